// File: rtl/handshakes_all.sv
// handshakes_all: registered valid/ready slice built as a two-entry skid buffer.
// Define HANDSHAKES_ALL_ASSERT_EN to compile in simulation protocol checkers.
module handshakes_all #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_valid,
  input  logic [WORD_WIDTH-1:0] up_data,
  input  logic                  down_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  output logic                  up_ready
);

  // Encoding mirrors {skid_valid, main_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e                state_q;
  logic [WORD_WIDTH-1:0] main_q;
  logic [WORD_WIDTH-1:0] skid_q;
  logic                  down_valid_q;
  logic                  up_ready_q;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = up_valid & up_ready_q;
  assign out_xfer = down_valid_q & down_ready;

  assign down_valid = down_valid_q;
  assign down_data  = main_q;
  assign up_ready   = up_ready_q;

  // Occupancy FSM; both handshake outputs are flops updated with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      down_valid_q <= 1'b0;
      up_ready_q   <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_q       <= up_data;
            down_valid_q <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_q <= up_data;
          end else if (in_xfer) begin
            skid_q     <= up_data;
            up_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (out_xfer) begin
            down_valid_q <= 1'b0;
            state_q      <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            skid_q     <= '0;
            up_ready_q <= 1'b1;
            state_q    <= BUSY;
          end
        end
        default: begin
          state_q      <= EMPTY;
          down_valid_q <= 1'b0;
          up_ready_q   <= 1'b1;
        end
      endcase
    end
  end

`ifdef HANDSHAKES_ALL_ASSERT_EN
  logic                  up_stall_q;
  logic                  dn_stall_q;
  logic [WORD_WIDTH-1:0] up_data_q;
  logic [WORD_WIDTH-1:0] dn_data_q;

  // Protocol checks against last cycle's stalled handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_stall_q <= 1'b0;
      dn_stall_q <= 1'b0;
      up_data_q  <= '0;
      dn_data_q  <= '0;
    end else begin
      up_stall_q <= up_valid & ~up_ready_q;
      dn_stall_q <= down_valid_q & ~down_ready;
      up_data_q  <= up_data;
      dn_data_q  <= main_q;
      if (up_stall_q && !up_valid)
        $error("up_valid dropped while stalled");
      if (up_stall_q && up_valid && (up_data != up_data_q))
        $error("up_data changed while stalled");
      if ((state_q == FULL) && in_xfer)
        $error("input transfer while FULL");
      if (dn_stall_q && (main_q != dn_data_q))
        $error("down_data changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_handshakes_all.sv
// tb_handshakes_all: directed checks plus an alternating-ready scoreboard run.
module tb_handshakes_all;

  logic       clk;
  logic       rst_n;
  logic       up_valid;
  logic [7:0] up_data;
  logic       down_ready;
  logic       down_valid;
  logic [7:0] down_data;
  logic       up_ready;

  int         n_chk;
  int         n_err;
  int         sent;
  int         got;
  logic [7:0] q[$];
  logic [7:0] exp_b;
  logic [7:0] held;
  logic       in_acc;
  logic       out_acc;
  logic       hold;

  handshakes_all #(.WORD_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .down_ready (down_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .up_ready   (up_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic dv,
                      input logic [7:0] dd, input logic ur);
    chk({tag, "_dv"}, {31'd0, down_valid}, {31'd0, dv});
    chk({tag, "_dd"}, {24'd0, down_data}, {24'd0, dd});
    chk({tag, "_ur"}, {31'd0, up_ready}, {31'd0, ur});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b1;
    up_valid = 1'b1;
    up_data = 8'hFF;
    down_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 outs("rst_a", 1'b0, 8'h00, 1'b1);
    #17 outs("rst_b", 1'b0, 8'h00, 1'b1);
    #16 outs("rst_c", 1'b0, 8'h00, 1'b1);
    #1 rst_n = 1'b1;
    up_valid = 1'b0;
    #1 outs("rel", 1'b0, 8'h00, 1'b1);

    // streaming
    up_valid = 1'b1;
    up_data = 8'h11;
    step();
    outs("s11", 1'b1, 8'h11, 1'b1);
    up_data = 8'h22;
    step();
    outs("s22", 1'b1, 8'h22, 1'b1);
    up_data = 8'h33;
    step();
    outs("s33", 1'b1, 8'h33, 1'b1);
    up_valid = 1'b0;
    step();
    chk("s_end_dv", {31'd0, down_valid}, 32'd0);

    // stall fill
    down_ready = 1'b0;
    up_valid = 1'b1;
    up_data = 8'hA5;
    step();
    outs("f1", 1'b1, 8'hA5, 1'b1);
    up_data = 8'h5A;
    step();
    outs("f2", 1'b1, 8'hA5, 1'b0);
    up_valid = 1'b0;
    step();
    outs("f3", 1'b1, 8'hA5, 1'b0);

    // drain
    down_ready = 1'b1;
    step();
    outs("d1", 1'b1, 8'h5A, 1'b1);
    step();
    chk("d2_dv", {31'd0, down_valid}, 32'd0);
    chk("d2_ur", {31'd0, up_ready}, 32'd1);

    // alternating ready with random producer
    sent = 0;
    got = 0;
    up_valid = 1'b1;
    up_data = 8'($urandom_range(0, 255));
    for (int i = 0; i < 200; i++) begin
      if (sent >= 16 && q.size() == 0) break;
      down_ready = (sent < 16) ? i[0] : 1'b1;
      #0;
      in_acc = up_valid && up_ready;
      out_acc = down_valid && down_ready;
      hold = down_valid && !down_ready;
      held = down_data;
      if (out_acc) begin
        got++;
        if (q.size() == 0) begin
          chk("alt_extra", 32'd1, 32'd0);
        end else begin
          exp_b = q.pop_front();
          chk("alt_data", {24'd0, down_data}, {24'd0, exp_b});
        end
      end
      if (in_acc) q.push_back(up_data);
      step();
      if (hold) chk("alt_hold", {24'd0, down_data}, {24'd0, held});
      if (in_acc) begin
        sent++;
        if (sent < 16) up_data = 8'($urandom_range(0, 255));
        else up_valid = 1'b0;
      end
    end
    chk("alt_sent", sent, 16);
    chk("alt_got", got, 16);
    chk("alt_left", q.size(), 0);

    // mid-stream reset while FULL
    up_valid = 1'b1;
    down_ready = 1'b0;
    up_data = 8'h77;
    step();
    up_data = 8'h88;
    step();
    outs("m_full", 1'b1, 8'h77, 1'b0);
    #2 rst_n = 1'b0;
    #1 outs("m_rst", 1'b0, 8'h00, 1'b1);
    step();
    outs("m_hold", 1'b0, 8'h00, 1'b1);
    #2 rst_n = 1'b1;
    up_data = 8'h3C;
    down_ready = 1'b1;
    step();
    outs("m_3c", 1'b1, 8'h3C, 1'b1);
    up_valid = 1'b0;
    step();
    chk("m_end_dv", {31'd0, down_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
